window_gen: RTL and testbench

Sliding-window generator that feeds the convolution MAC. It accepts a raster-order pixel stream, one pixel per cycle, and buffers the two previous image rows in internal line buffers. For every valid 3x3 neighbourhood it presents nine registered pixels with a one-cycle valid strobe. That strobe drives the MAC's `start`/`en` directly, and the nine pixels drive `i0..i8`, so this block is the producing end of the MAC's window interface.

---
 rtl/window_gen_if.sv | 40 ++++
 rtl/window_gen.sv | 170 +++++++++++++++++
 tb/tb_window_gen.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/window_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : window_gen_if
//  Description : Pixel-in / window-out bundle for window_gen. The master
//                modport is the window producer (window_gen itself); the
//                slave modport is the environment that supplies pixels and
//                consumes windows (pixel source plus MAC).
//  Revision    : 1.0 - initial release
// ============================================================================
interface window_gen_if #(
    parameter int BITS = 8
);
    logic [BITS-1:0] pix_in;
    logic            pix_valid;
    logic [BITS-1:0] w0;
    logic [BITS-1:0] w1;
    logic [BITS-1:0] w2;
    logic [BITS-1:0] w3;
    logic [BITS-1:0] w4;
    logic [BITS-1:0] w5;
    logic [BITS-1:0] w6;
    logic [BITS-1:0] w7;
    logic [BITS-1:0] w8;
    logic            win_valid;
    logic            frame_done;
    logic            busy;

    modport master (
        input  pix_in, pix_valid,
        output w0, w1, w2, w3, w4, w5, w6, w7, w8,
        output win_valid, frame_done, busy
    );

    modport slave (
        output pix_in, pix_valid,
        input  w0, w1, w2, w3, w4, w5, w6, w7, w8,
        input  win_valid, frame_done, busy
    );
endinterface
`default_nettype wire

// File: rtl/window_gen.sv
`default_nettype none
// ============================================================================
//  Module      : window_gen
//  Description : 3x3 sliding-window generator for a raster pixel stream.
//                Two line buffers hold the previous two rows; a 3x3 register
//                window shifts one column per accepted pixel and a one-cycle
//                strobe marks each complete in-row neighbourhood.
//                Optional macro WINGEN_STRIDE2_EN: emit windows at stride 2
//                only (counters, buffers and frame_done are unaffected).
//  Revision    : 1.0 - initial release
// ============================================================================
module window_gen #(
    parameter int BITS  = 8,
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic         clk,
    input  logic         reset,
    window_gen_if.master bus
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;

    logic [BITS-1:0]  line0 [IMG_W];
    logic [BITS-1:0]  line1 [IMG_W];
    logic [BITS-1:0]  win   [9];

    logic             win_valid_reg;
    logic             frame_done_reg;
    logic             busy_reg;

    logic             accept;
    logic             col_last;
    logic             row_last;
    logic             frame_last;
    logic             emit;

    assign accept     = bus.pix_valid;
    assign col_last   = (col == COL_LAST);
    assign row_last   = (row == ROW_LAST);
    assign frame_last = accept & col_last & row_last;

    // Windows with c<2 would straddle two rows, so only c>=2 (and r>=2) emit.
`ifdef WINGEN_STRIDE2_EN
    assign emit = accept && (row >= ROW_W'(2)) && (col >= COL_W'(2))
                  && !row[0] && !col[0];
`else
    assign emit = accept && (row >= ROW_W'(2)) && (col >= COL_W'(2));
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: IDLE -> FILL on first pixel, FILL -> STREAM after row 1,
    // STREAM -> IDLE on the last pixel of the frame.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                if (accept && col_last && (row == ROW_W'(1))) begin
                    state_next = STREAM;
                end
            end
            STREAM: begin
                if (frame_last) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Raster position counters; both wrap together at the end of the frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    // Line buffers: line0 holds row r-2, line1 holds row r-1. Never cleared;
    // row gating keeps stale contents out of every emitted window.
    always_ff @(posedge clk) begin
        if (accept) begin
            line0[col] <= line1[col];
            line1[col] <= bus.pix_in;
        end
    end

    // 3x3 window shifts left; new right column is {row r-2, row r-1, row r}.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 9; k++) begin
                win[k] <= '0;
            end
        end else if (accept) begin
            win[0] <= win[1];
            win[1] <= win[2];
            win[2] <= line0[col];
            win[3] <= win[4];
            win[4] <= win[5];
            win[5] <= line1[col];
            win[6] <= win[7];
            win[7] <= win[8];
            win[8] <= bus.pix_in;
        end
    end

    // Registered status strobes aligned with the window they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_valid_reg  <= 1'b0;
            frame_done_reg <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            win_valid_reg  <= emit;
            frame_done_reg <= frame_last;
            busy_reg       <= (state_next != IDLE);
        end
    end

    assign bus.w0         = win[0];
    assign bus.w1         = win[1];
    assign bus.w2         = win[2];
    assign bus.w3         = win[3];
    assign bus.w4         = win[4];
    assign bus.w5         = win[5];
    assign bus.w6         = win[6];
    assign bus.w7         = win[7];
    assign bus.w8         = win[8];
    assign bus.win_valid  = win_valid_reg;
    assign bus.frame_done = frame_done_reg;
    assign bus.busy       = busy_reg;

endmodule
`default_nettype wire

// File: tb/tb_window_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_window_gen
//  Description : Directed self-checking bench for window_gen on an 8x8 frame
//                with pixel value 8r+c+offset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_window_gen;

    localparam int BITS  = 8;
    localparam int IMG_W = 8;
    localparam int IMG_H = 8;
`ifdef WINGEN_STRIDE2_EN
    localparam int WIN_PER_FRAME = 9;
`else
    localparam int WIN_PER_FRAME = 36;
`endif

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   fails  = 0;
    int   cycle  = 0;

    window_gen_if #(.BITS(BITS)) bus ();

    window_gen #(
        .BITS  (BITS),
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [BITS-1:0] win_at(input int k);
        case (k)
            0: return bus.w0;
            1: return bus.w1;
            2: return bus.w2;
            3: return bus.w3;
            4: return bus.w4;
            5: return bus.w5;
            6: return bus.w6;
            7: return bus.w7;
            default: return bus.w8;
        endcase
    endfunction

    // Pixel (r,c) of the window completed at (wr,wc), position k in row-major.
    function automatic logic [BITS-1:0] exp_pix(input int wr, input int wc,
                                                input int k, input int offset);
        return BITS'(8 * (wr - 2 + k / 3) + (wc - 2 + k % 3) + offset);
    endfunction

    function automatic bit exp_emit(input int r, input int c);
`ifdef WINGEN_STRIDE2_EN
        return (r >= 2) && (c >= 2) && (r % 2 == 0) && (c % 2 == 0);
`else
        return (r >= 2) && (c >= 2);
`endif
    endfunction

    task automatic test_reset();
        logic [BITS-1:0] v;
        reset         = 1'b1;
        bus.pix_valid = 1'b1;
        bus.pix_in    = 8'hAA;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 9; k++) begin
            v = win_at(k);
            checks++;
            if (v !== '0) begin
                fails++;
                $display("FAIL reset_w%0d got %0d want 0", k, v);
            end
        end
        checks++;
        if ({bus.win_valid, bus.frame_done, bus.busy} !== 3'b000) begin
            fails++;
            $display("FAIL reset_flags got %b want 000",
                     {bus.win_valid, bus.frame_done, bus.busy});
        end
        @(negedge clk);
        reset         = 1'b0;
        bus.pix_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL idle_busy got %b want 0", bus.busy);
        end
    endtask

    // Drives one full frame (optionally with random gaps) and checks every cycle.
    task automatic test_frame(input int offset, input bit gaps, input string tag,
                              output int nwin, output int done_cycle);
        bit emit;
        bit last;
        bit last_emit;
        int lr;
        int lc;
        logic [BITS-1:0] v;
        logic [BITS-1:0] e;
        nwin       = 0;
        done_cycle = -1;
        last_emit  = 1'b0;
        lr         = 0;
        lc         = 0;
        for (int r = 0; r < IMG_H; r++) begin
            for (int c = 0; c < IMG_W; c++) begin
                if (gaps && ($urandom_range(0, 1) == 1)) begin
                    int g;
                    g = int'($urandom_range(1, 3));
                    for (int i = 0; i < g; i++) begin
                        @(negedge clk);
                        bus.pix_valid = 1'b0;
                        bus.pix_in    = BITS'($urandom);
                        @(posedge clk);
                        #1;
                        checks++;
                        if ({bus.win_valid, bus.frame_done} !== 2'b00) begin
                            fails++;
                            $display("FAIL %s gap_strobe r=%0d c=%0d got %b want 00",
                                     tag, r, c, {bus.win_valid, bus.frame_done});
                        end
                        if (last_emit) begin
                            for (int k = 0; k < 9; k++) begin
                                v = win_at(k);
                                e = exp_pix(lr, lc, k, offset);
                                checks++;
                                if (v !== e) begin
                                    fails++;
                                    $display("FAIL %s gap_hold_w%0d got %0d want %0d",
                                             tag, k, v, e);
                                end
                            end
                        end
                    end
                end
                @(negedge clk);
                bus.pix_valid = 1'b1;
                bus.pix_in    = BITS'(8 * r + c + offset);
                @(posedge clk);
                #1;
                emit = exp_emit(r, c);
                last = (r == IMG_H - 1) && (c == IMG_W - 1);
                checks++;
                if (bus.win_valid !== emit) begin
                    fails++;
                    $display("FAIL %s win_valid r=%0d c=%0d got %b want %b",
                             tag, r, c, bus.win_valid, emit);
                end
                checks++;
                if (bus.frame_done !== last) begin
                    fails++;
                    $display("FAIL %s frame_done r=%0d c=%0d got %b want %b",
                             tag, r, c, bus.frame_done, last);
                end
                if (bus.frame_done === 1'b1) done_cycle = cycle;
                checks++;
                if (bus.busy !== !last) begin
                    fails++;
                    $display("FAIL %s busy r=%0d c=%0d got %b want %b",
                             tag, r, c, bus.busy, !last);
                end
                if (bus.win_valid === 1'b1) nwin++;
                if (emit) begin
                    for (int k = 0; k < 9; k++) begin
                        v = win_at(k);
                        e = exp_pix(r, c, k, offset);
                        checks++;
                        if (v !== e) begin
                            fails++;
                            $display("FAIL %s window r=%0d c=%0d w%0d got %0d want %0d",
                                     tag, r, c, k, v, e);
                        end
                    end
                end
                last_emit = emit;
                lr        = r;
                lc        = c;
            end
        end
    endtask

    task automatic test_continuous();
        int n;
        int d;
        test_frame(0, 1'b0, "cont", n, d);
        @(negedge clk);
        bus.pix_valid = 1'b0;
        checks++;
        if (n !== WIN_PER_FRAME) begin
            fails++;
            $display("FAIL cont_count got %0d want %0d", n, WIN_PER_FRAME);
        end
    endtask

    task automatic test_gaps();
        int n;
        int d;
        test_frame(0, 1'b1, "gaps", n, d);
        @(negedge clk);
        bus.pix_valid = 1'b0;
        checks++;
        if (n !== WIN_PER_FRAME) begin
            fails++;
            $display("FAIL gaps_count got %0d want %0d", n, WIN_PER_FRAME);
        end
    endtask

    task automatic test_reset_midframe();
        int n;
        int d;
        logic [BITS-1:0] v;
        for (int p = 0; p <= 30; p++) begin
            @(negedge clk);
            bus.pix_valid = 1'b1;
            bus.pix_in    = BITS'(p);
        end
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        for (int k = 0; k < 9; k++) begin
            v = win_at(k);
            checks++;
            if (v !== '0) begin
                fails++;
                $display("FAIL async_reset_w%0d got %0d want 0", k, v);
            end
        end
        checks++;
        if ({bus.win_valid, bus.frame_done, bus.busy} !== 3'b000) begin
            fails++;
            $display("FAIL async_reset_flags got %b want 000",
                     {bus.win_valid, bus.frame_done, bus.busy});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset         = 1'b0;
        bus.pix_valid = 1'b0;
        test_frame(100, 1'b0, "post_reset", n, d);
        @(negedge clk);
        bus.pix_valid = 1'b0;
        checks++;
        if (n !== WIN_PER_FRAME) begin
            fails++;
            $display("FAIL post_reset_count got %0d want %0d", n, WIN_PER_FRAME);
        end
    endtask

    task automatic test_back_to_back();
        int n1;
        int n2;
        int d1;
        int d2;
        test_frame(0, 1'b0, "b2b_f1", n1, d1);
        test_frame(64, 1'b0, "b2b_f2", n2, d2);
        @(negedge clk);
        bus.pix_valid = 1'b0;
        checks++;
        if (n1 + n2 !== 2 * WIN_PER_FRAME) begin
            fails++;
            $display("FAIL b2b_count got %0d want %0d", n1 + n2, 2 * WIN_PER_FRAME);
        end
        checks++;
        if ((d1 < 0) || (d2 - d1 !== IMG_W * IMG_H)) begin
            fails++;
            $display("FAIL b2b_done_spacing got %0d (d1=%0d) want %0d",
                     d2 - d1, d1, IMG_W * IMG_H);
        end
    endtask

    initial begin
        bus.pix_in    = '0;
        bus.pix_valid = 1'b0;
        reset         = 1'b1;
        test_reset();
        test_continuous();
        test_gaps();
        test_reset_midframe();
        test_back_to_back();
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
